// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the serial frame receiver
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - 1-bit running XOR accumulator with clear and enable
module parity_acc (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic acc_q;
  logic acc_d;

  // Clear has priority so a new frame starts from a known zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 1'b0;
    end else if (en_i) begin
      acc_d = acc_q ^ d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign q_o = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial start/data/parity/stop deframer with parity check and error count
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_i,
  input  logic              clr_cnt_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              par_err_o,
  output logic              frame_err_o,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              acc_clr, acc_en, acc_q;
  logic              frame_done;

  parity_acc u_acc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .d_i   (in_i),
    .q_o   (acc_q)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_i) begin
          state_d = DATA;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      DATA: begin
        sh_d[idx_q] = in_i;
        acc_en      = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = PARITY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        acc_en  = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        // Accumulator now holds XOR of data and parity bits.
        state_d    = IDLE;
        frame_done = 1'b1;
        data_d     = sh_q;
        valid_d    = 1'b1;
        perr_d     = acc_q ^ ODD_PARITY;
        ferr_d     = ~in_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (frame_done && (perr_d || ferr_d) && (cnt_q != ERR_CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign par_err_o   = perr_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);
  assign err_cnt_o   = cnt_q;

endmodule
